fetch_unit: RTL and testbench

//  IF stage: producer of FetchData_IF, the instruction word the ID stage consumes. Owns the PC,

---
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/grant and in-order response bus
interface fetch_unit_if;
    logic        IMemReq_IF;
    logic [31:0] IMemAddr_IF;
    logic        IMemGnt;
    logic        IMemRdValid;
    logic [31:0] IMemRdData;
    modport master (output IMemReq_IF, IMemAddr_IF, input IMemGnt, IMemRdValid, IMemRdData);
    modport slave (input IMemReq_IF, IMemAddr_IF, output IMemGnt, IMemRdValid, IMemRdData);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with PC, credit-limited prefetch into a word queue, and jump/branch redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                AnyStall,
    input  logic                Jump_ID,
    input  logic [25:0]         JumpTgt_ID,
    input  logic                BrTaken_EX,
    input  logic [31:0]         BrTgt_EX,
    fetch_unit_if.master        imem,
    output logic [31:0]         FetchData_IF,
    output logic [31:0]         FetchPc_IF,
    output logic                FetchValid_IF
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   pc_q, pc_d, rpc_q, rpc_d;
    logic [CW-1:0] cnt_q, cnt_d, outst_q, outst_d, drop_q, drop_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   qdata_q [QDEPTH];
    logic [31:0]   qdata_d [QDEPTH];
    logic [31:0]   qpc_q [QDEPTH];
    logic [31:0]   qpc_d [QDEPTH];
    logic [31:0]   fdata_q, fdata_d, fpc_q, fpc_d;
    logic          fvalid_q, fvalid_d, live_q;
    logic          redirect, hold, grant, push, pop;
    logic [31:0]   tgt;
    logic [CW:0]   credit;

    always_comb begin
        redirect = BrTaken_EX || Jump_ID;
        hold     = AnyStall && !BrTaken_EX;
        tgt      = BrTaken_EX ? BrTgt_EX : {fpc_q[31:28], JumpTgt_ID, 2'b00};
        credit   = {1'b0, cnt_q} + {1'b0, outst_q};
        imem.IMemReq_IF  = live_q && (credit < (CW+1)'(QDEPTH));
        imem.IMemAddr_IF = pc_q;
        grant    = imem.IMemReq_IF && imem.IMemGnt;
        push     = imem.IMemRdValid && drop_q == '0 && !redirect;
        pop      = !redirect && !AnyStall && cnt_q != '0;
        pc_d     = redirect ? tgt : pc_q + (grant ? 32'd4 : 32'd0);
        outst_d  = outst_q + CW'(grant) - CW'(imem.IMemRdValid);
        // every request still in flight after a redirect (including this cycle's grant) is stale
        drop_d   = redirect ? outst_d : drop_q - CW'(imem.IMemRdValid && drop_q != '0);
        rpc_d    = redirect ? tgt : rpc_q + (push ? 32'd4 : 32'd0);
        head_d   = redirect ? '0 : head_q + AW'(pop);
        tail_d   = redirect ? '0 : tail_q + AW'(push);
        cnt_d    = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
        qdata_d  = qdata_q;
        qpc_d    = qpc_q;
        if (push) begin
            qdata_d[tail_q] = imem.IMemRdData;
            qpc_d[tail_q]   = rpc_q;
        end
        fdata_d  = hold ? fdata_q : pop ? qdata_q[head_q] : 32'h0;
        fpc_d    = pop ? qpc_q[head_q] : fpc_q;
        fvalid_d = hold ? fvalid_q : pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            rpc_q    <= RESET_PC;
            cnt_q    <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            qdata_q  <= '{default: '0};
            qpc_q    <= '{default: '0};
            fdata_q  <= '0;
            fpc_q    <= RESET_PC;
            fvalid_q <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rpc_q    <= rpc_d;
            cnt_q    <= cnt_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            qdata_q  <= qdata_d;
            qpc_q    <= qpc_d;
            fdata_q  <= fdata_d;
            fpc_q    <= fpc_d;
            fvalid_q <= fvalid_d;
            live_q   <= 1'b1;
        end
    end

    assign FetchData_IF  = fdata_q;
    assign FetchPc_IF    = fpc_q;
    assign FetchValid_IF = fvalid_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && cnt_q == CW'(QDEPTH)) && drop_q <= CW'(QDEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests of fetch_unit against an in-order instruction memory model
module tb_fetch_unit;
    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        AnyStall = 1'b0;
    logic        Jump_ID = 1'b0;
    logic [25:0] JumpTgt_ID = '0;
    logic        BrTaken_EX = 1'b0;
    logic [31:0] BrTgt_EX = '0;
    logic [31:0] FetchData_IF, FetchPc_IF;
    logic        FetchValid_IF;

    fetch_unit_if imem();

    fetch_unit #(.RESET_PC(32'h0), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .AnyStall(AnyStall), .Jump_ID(Jump_ID),
        .JumpTgt_ID(JumpTgt_ID), .BrTaken_EX(BrTaken_EX), .BrTgt_EX(BrTgt_EX),
        .imem(imem), .FetchData_IF(FetchData_IF), .FetchPc_IF(FetchPc_IF),
        .FetchValid_IF(FetchValid_IF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t pend[$];
    int   cyc = 0, gcnt = 0, lat_fix = 1, vcnt = 0, max_occ = 0;
    bit   rand_lat = 0, gnt_en = 1, g_now = 0, mon_en = 0;
    int   checks = 0, failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // memory: decides grant/response on the falling edge, responses strictly in order
    initial begin
        imem.IMemGnt = 1'b0;
        imem.IMemRdValid = 1'b0;
        imem.IMemRdData = '0;
        forever begin
            @(negedge clk);
            cyc++;
            imem.IMemRdValid = 1'b0;
            imem.IMemRdData = '0;
            g_now = 1'b0;
            if (!reset_n) begin
                pend.delete();
                gcnt = 0;
                imem.IMemGnt = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    imem.IMemRdValid = 1'b1;
                    imem.IMemRdData = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end
                imem.IMemGnt = gnt_en;
                g_now = imem.IMemReq_IF && gnt_en;
                if (g_now) begin
                    pend.push_back('{imem.IMemAddr_IF, cyc + (rand_lat ? int'($urandom_range(1, 6)) : lat_fix)});
                    gcnt++;
                end
            end
        end
    end

    // granted-but-not-yet-delivered words, as visible from outside the DUT
    initial begin : occ_mon
        int occ;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                vcnt += int'(FetchValid_IF);
                occ = gcnt - int'(g_now) - vcnt;
                if (occ > max_occ) max_occ = occ;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input bit rl);
        reset_n = 1'b0;
        AnyStall = 1'b0;
        Jump_ID = 1'b0;
        BrTaken_EX = 1'b0;
        gnt_en = 1'b1;
        lat_fix = lat;
        rand_lat = rl;
        step();
        step();
        chk("rst_pc", FetchPc_IF, 32'h0);
        chk("rst_valid", FetchValid_IF, 1'b0);
        chk("rst_data", FetchData_IF, 32'h0);
        chk("rst_req", imem.IMemReq_IF, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] pc);
        int w = 0;
        while (!(FetchValid_IF && FetchPc_IF == pc) && w < 100) begin
            step();
            w++;
        end
        chk(tag, FetchPc_IF, pc);
    endtask

    task automatic expect_seq(input string tag, input logic [31:0] start, input int n, input bit contig);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            step();
            while (!FetchValid_IF && w < 60) begin
                step();
                w++;
            end
            if (contig && i > 0) chk({tag, "_gap"}, w, 0);
            chk({tag, "_v"}, FetchValid_IF, 1'b1);
            chk({tag, "_pc"}, FetchPc_IF, start + 32'(4 * i));
            chk({tag, "_dat"}, FetchData_IF, mem_word(start + 32'(4 * i)));
        end
    endtask

    initial begin
        int w, seen;
        // 1: latency 1, streaming
        do_reset(1, 0);
        expect_seq("t1", 32'h0, 8, 1);

        // 2: stall at 0x10 fills exactly the credits, then drains gap-free
        do_reset(1, 0);
        wait_pc("t2_at10", 32'h10);
        AnyStall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_hold_pc", FetchPc_IF, 32'h10);
            chk("t2_hold_v", FetchValid_IF, 1'b1);
        end
        chk("t2_grants", gcnt, 9);
        chk("t2_req_off", imem.IMemReq_IF, 1'b0);
        AnyStall = 1'b0;
        expect_seq("t2", 32'h14, 8, 1);

        // 3: jump with delay slot at 0x20
        do_reset(1, 0);
        wait_pc("t3_slot", 32'h20);
        Jump_ID = 1'b1;
        JumpTgt_ID = 26'h40;
        step();
        Jump_ID = 1'b0;
        chk("t3_bub_v", FetchValid_IF, 1'b0);
        chk("t3_bub_d", FetchData_IF, 32'h0);
        chk("t3_bub_pc", FetchPc_IF, 32'h20);
        expect_seq("t3", 32'h100, 3, 0);

        // 3b: jump while stalled keeps the delay slot on the output
        do_reset(1, 0);
        wait_pc("t3s_slot", 32'h20);
        Jump_ID = 1'b1;
        JumpTgt_ID = 26'h40;
        AnyStall = 1'b1;
        step();
        Jump_ID = 1'b0;
        AnyStall = 1'b0;
        chk("t3s_hold_pc", FetchPc_IF, 32'h20);
        chk("t3s_hold_v", FetchValid_IF, 1'b1);
        step();
        chk("t3s_bub_v", FetchValid_IF, 1'b0);
        expect_seq("t3s", 32'h100, 2, 0);

        // 4: branch with 3 requests in flight at latency 4, stall ignored by the branch
        do_reset(4, 0);
        w = 0;
        while (!FetchValid_IF && w < 50) begin
            step();
            w++;
        end
        chk("t4_first_v", FetchValid_IF, 1'b1);
        w = 0;
        while (pend.size() != 3 && w < 50) begin
            step();
            w++;
        end
        chk("t4_inflight", pend.size(), 3);
        BrTaken_EX = 1'b1;
        BrTgt_EX = 32'h200;
        AnyStall = 1'b1;
        step();
        BrTaken_EX = 1'b0;
        AnyStall = 1'b0;
        chk("t4_nop_v", FetchValid_IF, 1'b0);
        chk("t4_nop_d", FetchData_IF, 32'h0);
        expect_seq("t4", 32'h200, 3, 0);

        // 5: branch and jump together, branch wins
        do_reset(1, 0);
        wait_pc("t5_at8", 32'h8);
        BrTaken_EX = 1'b1;
        BrTgt_EX = 32'h300;
        Jump_ID = 1'b1;
        JumpTgt_ID = 26'h80;
        step();
        BrTaken_EX = 1'b0;
        Jump_ID = 1'b0;
        chk("t5_nop_v", FetchValid_IF, 1'b0);
        expect_seq("t5", 32'h300, 3, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (FetchValid_IF && FetchPc_IF == 32'h200) seen++;
        end
        chk("t5_no_jtgt", seen, 0);

        // 6: grant withheld, then random latency
        do_reset(1, 1);
        gnt_en = 1'b0;
        vcnt = 0;
        max_occ = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_req_held", imem.IMemReq_IF, 1'b1);
            chk("t6_addr_held", imem.IMemAddr_IF, 32'h0);
        end
        gnt_en = 1'b1;
        expect_seq("t6", 32'h0, 20, 0);
        mon_en = 1'b0;
        chk("t6_occ_le_qdepth", max_occ <= QDEPTH, 1'b1);

        // 7: pc wraps modulo 2^32
        do_reset(1, 0);
        wait_pc("t7_at8", 32'h8);
        BrTaken_EX = 1'b1;
        BrTgt_EX = 32'hFFFF_FFF8;
        step();
        BrTaken_EX = 1'b0;
        expect_seq("t7", 32'hFFFF_FFF8, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
